// File: rtl/cache_l2_responder.sv
// rtl/cache_l2_responder.sv - L2 responder: direct-mapped write-back array serving L1 reads, word writes and write-backs
//
// Purpose: accepts one L1 request at a time (write-back > word write > read),
// looks it up in a direct-mapped write-back L2, evicts a dirty victim and/or
// fills from the next memory level when needed, then acknowledges with a
// one-cycle pulse. The responder holds in RELEASE until every L1 request line
// is low, so a request that stays high is never served twice.
//
// Ports:
//   clk, reset                     clock (rising edge), asynchronous active-low reset
//   read_from_L2_request           L1 block read, held until L2_ready
//   write_to_L2_request            L1 word write, held until write_to_L2_verified
//   write_back_to_L2_request       L1 dirty block write-back, held until write_back_to_L2_verified
//   cache_L2_memory_address        request byte address ([31:30] processor ID, ignored)
//   cache_write_data               word for a word write
//   write_back_to_L2_data          block for a write-back
//   mem_ready, mem_read_data       fill pulse and fill block from memory
//   mem_write_done                 eviction accepted pulse from memory
//   write_data_to_L1_from_L2       block returned to L1, valid while L2_ready
//   L2_ready, write_to_L2_verified, write_back_to_L2_verified   acknowledge pulses
//   L2_cache_hit, L2_cache_miss    lookup result pulses
//   mem_address                    block-aligned memory address
//   mem_read_request, mem_write_request   level requests to memory
//   mem_write_data                 victim block being evicted
module cache_l2_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int L2_SETS       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_from_L2_request,
  input  logic                     write_to_L2_request,
  input  logic                     write_back_to_L2_request,
  input  logic [ADDRESS_WIDTH-1:0] cache_L2_memory_address,
  input  logic [DATA_WIDTH-1:0]    cache_write_data,
  input  logic [BLOCK_WIDTH-1:0]   write_back_to_L2_data,
  input  logic                     mem_ready,
  input  logic [BLOCK_WIDTH-1:0]   mem_read_data,
  input  logic                     mem_write_done,
  output logic [BLOCK_WIDTH-1:0]   write_data_to_L1_from_L2,
  output logic                     L2_ready,
  output logic                     write_to_L2_verified,
  output logic                     write_back_to_L2_verified,
  output logic                     L2_cache_hit,
  output logic                     L2_cache_miss,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_read_request,
  output logic                     mem_write_request,
  output logic [BLOCK_WIDTH-1:0]   mem_write_data
);

  localparam int WORDS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int OW    = $clog2(WORDS);
  localparam int IW    = $clog2(L2_SETS);
  // Line address excludes the two processor-ID bits and the two byte bits.
  localparam int LW    = ADDRESS_WIDTH - 4;
  localparam int TW    = LW - OW - IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FETCH,
    S_RESPOND,
    S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    REQ_READ,
    REQ_WRITE,
    REQ_WB
  } req_t;

  state_t state, state_next;
  req_t   req_type;

  logic [LW-1:0]          req_line;
  logic [DATA_WIDTH-1:0]  req_word;
  logic [BLOCK_WIDTH-1:0] req_block;

  logic [BLOCK_WIDTH-1:0] data_arr  [L2_SETS];
  logic [TW-1:0]          tag_arr   [L2_SETS];
  logic [L2_SETS-1:0]     valid_arr;
  logic [L2_SETS-1:0]     dirty_arr;

  logic [OW-1:0]          req_off;
  logic [IW-1:0]          req_idx;
  logic [TW-1:0]          req_tag;
  logic                   line_hit;
  logic                   victim_dirty;
  logic                   any_req;
  logic                   enter_respond;
  logic [BLOCK_WIDTH-1:0] merged_line;

  // Processor ID and byte-select bits play no part in the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cache_L2_memory_address[ADDRESS_WIDTH-1:ADDRESS_WIDTH-2],
                              cache_L2_memory_address[1:0]};

  assign req_off       = req_line[OW-1:0];
  assign req_idx       = req_line[OW +: IW];
  assign req_tag       = req_line[OW+IW +: TW];
  assign line_hit      = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
  assign victim_dirty  = valid_arr[req_idx] && dirty_arr[req_idx];
  assign any_req       = read_from_L2_request | write_to_L2_request | write_back_to_L2_request;
  assign enter_respond = (state_next == S_RESPOND);

  // Line with the requested word replaced; the OW-bit offset selects one of
  // WORDS slots, so the write can never land outside the block.
  always_comb begin
    merged_line = data_arr[req_idx];
    for (int w = 0; w < WORDS; w++) begin
      if (req_off == OW'(w)) begin
        merged_line[w*DATA_WIDTH +: DATA_WIDTH] = req_word;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (any_req) state_next = S_LOOKUP;
      S_LOOKUP: begin
        if (line_hit)              state_next = S_RESPOND;
        else if (victim_dirty)     state_next = S_EVICT;
        else if (req_type == REQ_WB) state_next = S_RESPOND;
        else                       state_next = S_FETCH;
      end
      S_EVICT: begin
        if (mem_write_done) state_next = (req_type == REQ_WB) ? S_RESPOND : S_FETCH;
      end
      S_FETCH:   if (mem_ready) state_next = S_RESPOND;
      S_RESPOND: state_next = S_RELEASE;
      S_RELEASE: if (!any_req) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Memory-side outputs follow the state register, so reset drops them at once.
  always_comb begin
    mem_read_request  = 1'b0;
    mem_write_request = 1'b0;
    mem_address       = '0;
    mem_write_data    = '0;
    case (state)
      S_EVICT: begin
        mem_write_request = 1'b1;
        mem_address       = {2'b00, tag_arr[req_idx], req_idx, {(OW+2){1'b0}}};
        mem_write_data    = data_arr[req_idx];
      end
      S_FETCH: begin
        mem_read_request = 1'b1;
        mem_address      = {2'b00, req_tag, req_idx, {(OW+2){1'b0}}};
      end
      default: ;
    endcase
  end

  // Control state, latched request and registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                     <= S_IDLE;
      req_type                  <= REQ_READ;
      req_line                  <= '0;
      req_word                  <= '0;
      req_block                 <= '0;
      L2_cache_hit              <= 1'b0;
      L2_cache_miss             <= 1'b0;
      L2_ready                  <= 1'b0;
      write_to_L2_verified      <= 1'b0;
      write_back_to_L2_verified <= 1'b0;
      write_data_to_L1_from_L2  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && any_req) begin
        if (write_back_to_L2_request)  req_type <= REQ_WB;
        else if (write_to_L2_request)  req_type <= REQ_WRITE;
        else                           req_type <= REQ_READ;
        req_line  <= cache_L2_memory_address[ADDRESS_WIDTH-3:2];
        req_word  <= cache_write_data;
        req_block <= write_back_to_L2_data;
      end
      L2_cache_hit  <= (state == S_LOOKUP) && line_hit;
      L2_cache_miss <= (state == S_LOOKUP) && !line_hit;
      // Acks are raised on entry to RESPOND so they are visible during it.
      L2_ready                  <= enter_respond && (req_type == REQ_READ);
      write_to_L2_verified      <= enter_respond && (req_type == REQ_WRITE);
      write_back_to_L2_verified <= enter_respond && (req_type == REQ_WB);
      if (enter_respond && req_type == REQ_READ) begin
        // A read reaches RESPOND either straight from a hit or from a fill.
        write_data_to_L1_from_L2 <= (state == S_FETCH) ? mem_read_data : data_arr[req_idx];
      end else begin
        write_data_to_L1_from_L2 <= '0;
      end
    end
  end

  // L2 array: valid/dirty/tag/data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_arr <= '0;
      dirty_arr <= '0;
      for (int s = 0; s < L2_SETS; s++) begin
        data_arr[s] <= '0;
        tag_arr[s]  <= '0;
      end
    end else begin
      case (state)
        S_EVICT: if (mem_write_done) dirty_arr[req_idx] <= 1'b0;
        S_FETCH: begin
          if (mem_ready) begin
            data_arr[req_idx]  <= mem_read_data;
            tag_arr[req_idx]   <= req_tag;
            valid_arr[req_idx] <= 1'b1;
            dirty_arr[req_idx] <= 1'b0;
          end
        end
        S_RESPOND: begin
          if (req_type == REQ_WRITE) begin
            data_arr[req_idx]  <= merged_line;
            dirty_arr[req_idx] <= 1'b1;
          end else if (req_type == REQ_WB) begin
            data_arr[req_idx]  <= req_block;
            tag_arr[req_idx]   <= req_tag;
            valid_arr[req_idx] <= 1'b1;
            dirty_arr[req_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_l2_responder.sv
// tb/tb_cache_l2_responder.sv - scoreboard bench for cache_l2_responder
module tb_cache_l2_responder;

  localparam int EV_HIT  = 0;
  localparam int EV_MISS = 1;
  localparam int EV_MWR  = 2;
  localparam int EV_MRD  = 3;
  localparam int EV_RDY  = 4;
  localparam int EV_WV   = 5;
  localparam int EV_WBV  = 6;

  localparam logic [127:0] B1 = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
  localparam logic [127:0] B2 = 128'h01234567_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] B3 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] B4 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] BA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] BC = 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC;
  localparam logic [127:0] B5 = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] B6 = 128'h12345678_55555555_55555555_55555555;
  localparam logic [127:0] B7 = 128'h77777777_77777777_77777777_77777777;
  localparam logic [127:0] B8 = 128'h88888888_88888888_88888888_88888888;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
  } ev_t;

  logic         clk;
  logic         reset;
  logic         read_from_L2_request, write_to_L2_request, write_back_to_L2_request;
  logic [31:0]  cache_L2_memory_address;
  logic [31:0]  cache_write_data;
  logic [127:0] write_back_to_L2_data;
  logic         mem_ready;
  logic [127:0] mem_read_data;
  logic         mem_write_done;
  logic [127:0] write_data_to_L1_from_L2;
  logic         L2_ready, write_to_L2_verified, write_back_to_L2_verified;
  logic         L2_cache_hit, L2_cache_miss;
  logic [31:0]  mem_address;
  logic         mem_read_request, mem_write_request;
  logic [127:0] mem_write_data;

  int           checks = 0;
  int           errors = 0;
  ev_t          exp_q[$];
  int           fill_delay = 0;
  int           evict_delay = 0;
  logic [127:0] fill_data = '0;

  cache_l2_responder dut (
    .clk                      (clk),
    .reset                    (reset),
    .read_from_L2_request     (read_from_L2_request),
    .write_to_L2_request      (write_to_L2_request),
    .write_back_to_L2_request (write_back_to_L2_request),
    .cache_L2_memory_address  (cache_L2_memory_address),
    .cache_write_data         (cache_write_data),
    .write_back_to_L2_data    (write_back_to_L2_data),
    .mem_ready                (mem_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_done           (mem_write_done),
    .write_data_to_L1_from_L2 (write_data_to_L1_from_L2),
    .L2_ready                 (L2_ready),
    .write_to_L2_verified     (write_to_L2_verified),
    .write_back_to_L2_verified(write_back_to_L2_verified),
    .L2_cache_hit             (L2_cache_hit),
    .L2_cache_miss            (L2_cache_miss),
    .mem_address              (mem_address),
    .mem_read_request         (mem_read_request),
    .mem_write_request        (mem_write_request),
    .mem_write_data           (mem_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int k, input logic [31:0] a, input logic [127:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [31:0] a, input logic [127:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h (none expected)", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL event got kind=%0d addr=%h data=%h exp kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: observes DUT outputs on the falling edge, in a fixed per-cycle order.
  initial begin
    logic prev_rd, prev_wr;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (L2_cache_hit)  check_ev(EV_HIT, 32'h0, 128'h0);
      if (L2_cache_miss) check_ev(EV_MISS, 32'h0, 128'h0);
      if (mem_write_request && !prev_wr) check_ev(EV_MWR, mem_address, mem_write_data);
      if (mem_read_request && !prev_rd)  check_ev(EV_MRD, mem_address, 128'h0);
      if (L2_ready)                  check_ev(EV_RDY, 32'h0, write_data_to_L1_from_L2);
      if (write_to_L2_verified)      check_ev(EV_WV, 32'h0, 128'h0);
      if (write_back_to_L2_verified) check_ev(EV_WBV, 32'h0, 128'h0);
      prev_rd = mem_read_request;
      prev_wr = mem_write_request;
    end
  end

  // Memory model: answers level requests after the configured number of cycles.
  initial begin
    mem_ready      = 1'b0;
    mem_write_done = 1'b0;
    mem_read_data  = '0;
    @(negedge clk);
    forever begin
      if (mem_write_request) begin
        for (int i = 0; i < evict_delay && mem_write_request; i++) @(negedge clk);
        if (mem_write_request) begin
          mem_write_done = 1'b1;
          @(negedge clk);
          mem_write_done = 1'b0;
        end
      end else if (mem_read_request) begin
        for (int i = 0; i < fill_delay && mem_read_request; i++) @(negedge clk);
        if (mem_read_request) begin
          mem_read_data = fill_data;
          mem_ready     = 1'b1;
          @(negedge clk);
          mem_ready     = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Entered and left at posedge+1. exp_lat<=0 skips the latency check.
  task automatic do_op(input logic rd, input logic wr, input logic wb,
                       input logic [31:0] addr, input logic [31:0] word,
                       input logic [127:0] blk, input int ack_kind,
                       input int exp_lat, input int hold, input int gap);
    int   n;
    logic got;
    read_from_L2_request     = rd;
    write_to_L2_request      = wr;
    write_back_to_L2_request = wb;
    cache_L2_memory_address  = addr;
    cache_write_data         = word;
    write_back_to_L2_data    = blk;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      case (ack_kind)
        EV_RDY:  got = L2_ready;
        EV_WV:   got = write_to_L2_verified;
        default: got = write_back_to_L2_verified;
      endcase
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout addr=%h got no ack after %0d cycles, required ack kind %0d", addr, n, ack_kind);
    end else if (exp_lat > 0) begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL latency addr=%h got %0d cycles, required %0d", addr, n, exp_lat);
      end
    end
    repeat (hold) @(posedge clk);
    if (hold > 0) #1;
    read_from_L2_request     = 1'b0;
    write_to_L2_request      = 1'b0;
    write_back_to_L2_request = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({write_data_to_L1_from_L2, L2_ready, write_to_L2_verified, write_back_to_L2_verified,
         L2_cache_hit, L2_cache_miss, mem_address, mem_read_request, mem_write_request,
         mem_write_data} != '0) begin
      errors++;
      $display("FAIL %s outputs not all zero: ready=%b wv=%b wbv=%b hit=%b miss=%b mrd=%b mwr=%b maddr=%h, required 0",
               name, L2_ready, write_to_L2_verified, write_back_to_L2_verified, L2_cache_hit,
               L2_cache_miss, mem_read_request, mem_write_request, mem_address);
    end
  endtask

  initial begin
    int n;
    reset                    = 1'b0;
    read_from_L2_request     = 1'b0;
    write_to_L2_request      = 1'b0;
    write_back_to_L2_request = 1'b0;
    cache_L2_memory_address  = '0;
    cache_write_data         = '0;
    write_back_to_L2_data    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("reset_quiet");
    end
    @(posedge clk);
    #1;

    // Clean read miss, then hits
    fill_data = B1; fill_delay = 3; evict_delay = 0;
    push(EV_MISS, 0, 0); push(EV_MRD, 32'h40, 0); push(EV_RDY, 0, B1);
    do_op(1, 0, 0, 32'h40, 0, 0, EV_RDY, 6, 0, 2);
    push(EV_HIT, 0, 0); push(EV_RDY, 0, B1);
    do_op(1, 0, 0, 32'h44, 0, 0, EV_RDY, 2, 0, 2);

    // Word write hit at offset 2, then read back
    push(EV_HIT, 0, 0); push(EV_WV, 0, 0);
    do_op(0, 1, 0, 32'h48, 32'hDEADBEEF, 0, EV_WV, 2, 0, 2);
    push(EV_HIT, 0, 0); push(EV_RDY, 0, B2);
    do_op(1, 0, 0, 32'h40, 0, 0, EV_RDY, 2, 0, 2);

    // Dirty conflict: evict 0x40 before filling 0x440
    fill_data = B3; fill_delay = 1; evict_delay = 2;
    push(EV_MISS, 0, 0); push(EV_MWR, 32'h40, B2); push(EV_MRD, 32'h440, 0); push(EV_RDY, 0, B3);
    do_op(1, 0, 0, 32'h440, 0, 0, EV_RDY, 0, 0, 2);

    // Write-back miss on an invalid line: no fill
    push(EV_MISS, 0, 0); push(EV_WBV, 0, 0);
    do_op(0, 0, 1, 32'h80, 0, BA, EV_WBV, 2, 0, 2);
    fill_data = B4; fill_delay = 0; evict_delay = 0;
    push(EV_MISS, 0, 0); push(EV_MWR, 32'h80, BA); push(EV_MRD, 32'h880, 0); push(EV_RDY, 0, B4);
    do_op(1, 0, 0, 32'h880, 0, 0, EV_RDY, 0, 0, 2);

    // Read and write-back together: write-back wins
    push(EV_MISS, 0, 0); push(EV_WBV, 0, 0);
    do_op(1, 0, 1, 32'hC0, 0, BC, EV_WBV, 2, 0, 2);
    push(EV_HIT, 0, 0); push(EV_RDY, 0, BC);
    do_op(1, 0, 0, 32'hC0, 0, 0, EV_RDY, 2, 0, 2);

    // Held read: one ack only; re-request after one low cycle is accepted
    push(EV_HIT, 0, 0); push(EV_RDY, 0, B3);
    do_op(1, 0, 0, 32'h444, 0, 0, EV_RDY, 2, 5, 1);
    push(EV_HIT, 0, 0); push(EV_RDY, 0, B4);
    do_op(1, 0, 0, 32'h884, 0, 0, EV_RDY, 2, 0, 2);

    // Word write miss at the last offset, then read back
    fill_data = B5; fill_delay = 0;
    push(EV_MISS, 0, 0); push(EV_MRD, 32'h100, 0); push(EV_WV, 0, 0);
    do_op(0, 1, 0, 32'h10C, 32'h12345678, 0, EV_WV, 3, 0, 2);
    push(EV_HIT, 0, 0); push(EV_RDY, 0, B6);
    do_op(1, 0, 0, 32'h100, 0, 0, EV_RDY, 2, 0, 2);

    // Reset in the middle of FETCH
    fill_data = B7; fill_delay = 50;
    push(EV_MISS, 0, 0); push(EV_MRD, 32'h2D0, 0);
    read_from_L2_request    = 1'b1;
    cache_L2_memory_address = 32'h2D0;
    n = 0;
    while (!mem_read_request && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!mem_read_request) begin
      errors++;
      $display("FAIL fetch_start mem_read_request=%b, required 1", mem_read_request);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_read_request !== 1'b0 || mem_write_request !== 1'b0) begin
      errors++;
      $display("FAIL async_reset mem_read_request=%b mem_write_request=%b, required 0 0",
               mem_read_request, mem_write_request);
    end
    read_from_L2_request = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    fill_delay = 0;
    @(posedge clk);
    #1;

    // Arrays cleared: previous valid line misses; previous dirty line needs no eviction
    push(EV_MISS, 0, 0); push(EV_MRD, 32'h40, 0); push(EV_RDY, 0, B7);
    do_op(1, 0, 0, 32'h40, 0, 0, EV_RDY, 3, 0, 2);
    fill_data = B8;
    push(EV_MISS, 0, 0); push(EV_MRD, 32'h200, 0); push(EV_RDY, 0, B8);
    do_op(1, 0, 0, 32'h200, 0, 0, EV_RDY, 3, 0, 2);

    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d unobserved, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_l2_responder.md
# cache_l2_responder

L2-side responder for the L1↔L2 request interface: it serves L1 block reads, word writes (inclusion updates) and dirty-block write-backs, each closed with a one-cycle acknowledge pulse. It holds a direct-mapped, write-back L2 array. Misses are filled from the next memory level over a simple request/done handshake, with any dirty L2 victim evicted first. It sits between an L1 cache FSM and the main-memory model.

## Interface
- ADDRESS_WIDTH, 32, byte address width; bits [31:30] are the processor ID and are excluded from tag, index and offset.
- DATA_WIDTH, 32, word width of L1 word writes.
- BLOCK_WIDTH, 128, block width (matches MAIN_MEMORY_DATA_WIDTH).
- L2_SETS, 16, number of lines (power of 2); IW = log2(L2_SETS), OW = log2(BLOCK_WIDTH/DATA_WIDTH).
- Address split: word offset [OW+1:2], index [OW+2 +: IW], tag [29:OW+2+IW].
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_from_L2_request / write_to_L2_request / write_back_to_L2_request  in  1 each  L1 requests, held until acknowledged.
- cache_L2_memory_address  in  ADDRESS_WIDTH  request address.
- cache_write_data  in  DATA_WIDTH  word for write_to_L2_request.
- write_back_to_L2_data  in  BLOCK_WIDTH  block for write_back_to_L2_request.
- mem_ready  in  1  fill data valid (one-cycle pulse).
- mem_read_data  in  BLOCK_WIDTH  fill block.
- mem_write_done  in  1  eviction accepted (one-cycle pulse).
- write_data_to_L1_from_L2  out  BLOCK_WIDTH  block returned to L1, valid while L2_ready=1.
- L2_ready / write_to_L2_verified / write_back_to_L2_verified  out  1 each  acknowledge pulses.
- L2_cache_hit / L2_cache_miss  out  1 each  lookup result pulses.
- mem_address  out  ADDRESS_WIDTH  block-aligned (offset and byte bits zero) memory address.
- mem_read_request / mem_write_request  out  1 each  memory requests, level-held until mem_ready / mem_write_done.
- mem_write_data  out  BLOCK_WIDTH  victim block.

## Operation
- States: IDLE, LOOKUP, EVICT, FETCH, RESPOND, RELEASE.
- IDLE: on any request high, latch the request type, address, word and block, then go to LOOKUP. Priority when several are high: write-back > word write > read. Inputs are ignored outside IDLE.
- LOOKUP: hit = valid[idx] && tag[idx]==tag. Pulse L2_cache_hit or L2_cache_miss. Next state:
  - Hit: RESPOND.
  - Miss with valid and dirty victim: EVICT.
  - Miss otherwise: FETCH for read/word write; RESPOND for write-back (the full block is supplied, so no fill).
- EVICT:
  - mem_write_request=1; mem_address = {stored tag, idx, zeros}; mem_write_data = stored block.
  - On mem_write_done: clear dirty; go to FETCH (read/word write) or RESPOND (write-back).
- FETCH: mem_read_request=1, mem_address = aligned request address. On mem_ready: install mem_read_data, set tag, valid=1, dirty=0; go to RESPOND.
- RESPOND, one cycle:
  - Read: drive line onto write_data_to_L1_from_L2; pulse L2_ready.
  - Word write: replace word [offset*DATA_WIDTH +: DATA_WIDTH]; dirty=1; pulse write_to_L2_verified.
  - Write-back: install the whole block; tag, valid=1, dirty=1; pulse write_back_to_L2_verified.
  - Then go to RELEASE.
- RELEASE: stay until all three requests are low, then IDLE. This guarantees a held request is never served twice.
- A request dropped mid-operation does not abort it: the memory transaction completes and the acknowledge still pulses.

## Timing
- Reset (asynchronous, any state, including mid-EVICT/FETCH):
  - State goes to IDLE.
  - All outputs go to 0.
  - All valid, dirty, tag and data arrays are cleared.
  - mem_read_request and mem_write_request drop immediately.
- Request sampled at edge 0 → LOOKUP in cycle 1 → hit acknowledge in cycle 2 (2-cycle hit latency).
- Miss latency = 2 + eviction wait (if any) + fill wait (if any) + 1.
- Acknowledge, hit and miss outputs are registered and high for exactly one cycle.
- mem_ready or mem_write_done arriving in the same cycle the request rises is accepted; it completes the state at that edge.
- mem_* pulses outside EVICT/FETCH are ignored.
- Offset arithmetic uses an OW-bit unsigned index; the word position never wraps outside the block.

## Test plan
- Reset: deassert reset with no requests → all outputs 0 for 10 cycles; assert reset mid-FETCH → mem_read_request falls asynchronously and state returns to IDLE.
- Clean read miss, then hit:
  - Read 0x0000_0040; mem_ready 3 cycles after mem_read_request with block 0x0123..CDEF → mem_address=0x40, L2_ready pulse carrying that block.
  - Re-read 0x0000_0044 → L2_cache_hit and L2_ready 2 cycles after request, with no mem activity.
- Word write hit: write 0xDEADBEEF to 0x0000_0048 → write_to_L2_verified pulse; a following read returns bits [95:64]=0xDEADBEEF, other words unchanged.
- Dirty conflict: after the previous case, read 0x0000_0440 (same index, new tag) → mem_write_request with mem_address=0x40 and the dirty block precedes mem_read_request at 0x440; L2_ready follows mem_ready.
- Write-back miss on an invalid line: write-back of 0xAAAA..AAAA to 0x0000_0080 → write_back_to_L2_verified with no mem_read_request; later eviction of that line writes 0xAAAA..AAAA.
- Simultaneous events:
  - Read and write-back high together → write-back acknowledged first.
  - Read held high 5 cycles after L2_ready → exactly one L2_ready; a new read is accepted only after the request is low for one cycle.
